// File: rtl/pipeline_controller.sv
// Control and sequencing unit for the 5-stage MIPS pipeline: instruction decode,
// ID-stage branch/jump resolution, bring-up/halt/drain FSM and debug counters.
module pipeline_controller #(
  parameter int INIT_CYCLES  = 2,
  parameter int DRAIN_CYCLES = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  opcode,
  input  logic [5:0]  function_,
  input  logic        equal,
  input  logic        id_stall,
  input  logic        resume,
  output logic        Reg_Write_c,
  output logic        Mem_Read_c,
  output logic        Mem_Write_c,
  output logic        Mem_to_Reg_c,
  output logic        Reg_Dst_c,
  output logic [1:0]  ALU_src_c,
  output logic [2:0]  ALU_operation_c,
  output logic [1:0]  pc_src,
  output logic        flush,
  output logic        pc_hold,
  output logic        halted,
  output logic [31:0] cycle_count,
  output logic [31:0] instr_count,
  output logic [15:0] branch_count,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    S_INIT   = 2'd0,
    S_RUN    = 2'd1,
    S_DRAIN  = 2'd2,
    S_HALTED = 2'd3
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_HALT  = 6'b111111;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [3:0] INIT_LAST  = 4'(INIT_CYCLES - 1);
  localparam logic [3:0] DRAIN_LAST = 4'(DRAIN_CYCLES - 1);

  state_t      r_state;
  state_t      w_state_next;
  logic [3:0]  r_cnt;
  logic [3:0]  w_cnt_next;
  logic        r_flush_q;
  logic [31:0] r_cycle_count;
  logic [31:0] r_instr_count;
  logic [15:0] r_branch_count;

  logic       w_reg_write, w_mem_read, w_mem_write, w_mem_to_reg, w_reg_dst;
  logic [1:0] w_alu_src;
  logic [2:0] w_alu_op;
  logic       w_run, w_go, w_taken, w_halt_go, w_accept;

  always_comb begin
    w_reg_write  = 1'b0;
    w_mem_read   = 1'b0;
    w_mem_write  = 1'b0;
    w_mem_to_reg = 1'b0;
    w_reg_dst    = 1'b0;
    w_alu_src    = 2'b00;
    w_alu_op     = 3'b000;
    case (opcode)
      OP_RTYPE: begin
        case (function_)
          6'b100000: w_alu_op = ALU_ADD;
          6'b100010: w_alu_op = ALU_SUB;
          6'b100100: w_alu_op = ALU_AND;
          6'b100101: w_alu_op = ALU_OR;
          6'b101010: w_alu_op = ALU_SLT;
          default:   w_alu_op = 3'b000;
        endcase
        // An unrecognised funct must leave the whole bundle at zero.
        case (function_)
          6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010: begin
            w_reg_write = 1'b1;
            w_reg_dst   = 1'b1;
          end
          default: ;
        endcase
      end
      OP_LW: begin
        w_reg_write  = 1'b1;
        w_mem_read   = 1'b1;
        w_mem_to_reg = 1'b1;
        w_alu_src    = 2'b01;
        w_alu_op     = ALU_ADD;
      end
      OP_SW: begin
        w_mem_write = 1'b1;
        w_alu_src   = 2'b01;
        w_alu_op    = ALU_ADD;
      end
      OP_ADDI: begin
        w_reg_write = 1'b1;
        w_alu_src   = 2'b01;
        w_alu_op    = ALU_ADD;
      end
      OP_SLTI: begin
        w_reg_write = 1'b1;
        w_alu_src   = 2'b01;
        w_alu_op    = ALU_SLT;
      end
      OP_BEQ, OP_BNE: w_alu_op = ALU_SUB;
      default: ;
    endcase
  end

  assign w_run     = (r_state == S_RUN);
  assign w_go      = w_run && !id_stall;
  assign w_taken   = w_go && (((opcode == OP_BEQ) && equal) ||
                              ((opcode == OP_BNE) && !equal) ||
                              (opcode == OP_J));
  assign w_halt_go = w_go && (opcode == OP_HALT);
  // The slot in ID is a bubble when the previous cycle flushed IF/ID.
  assign w_accept  = w_go && !r_flush_q;

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    flush        = 1'b0;
    pc_hold      = 1'b0;
    pc_src       = 2'b00;
    halted       = 1'b0;
    case (r_state)
      S_INIT: begin
        flush   = 1'b1;
        pc_hold = 1'b1;
        if (r_cnt == INIT_LAST) begin
          w_state_next = S_RUN;
          w_cnt_next   = 4'd0;
        end else begin
          w_cnt_next = r_cnt + 4'd1;
        end
      end
      S_RUN: begin
        if (w_halt_go) begin
          pc_hold      = 1'b1;
          flush        = 1'b1;
          w_state_next = S_DRAIN;
          w_cnt_next   = 4'd0;
        end else if (w_taken) begin
          flush  = 1'b1;
          pc_src = (opcode == OP_J) ? 2'b10 : 2'b01;
        end
      end
      S_DRAIN: begin
        pc_hold = 1'b1;
        flush   = 1'b1;
        if (r_cnt == DRAIN_LAST) begin
          w_state_next = S_HALTED;
          w_cnt_next   = 4'd0;
        end else begin
          w_cnt_next = r_cnt + 4'd1;
        end
      end
      S_HALTED: begin
        halted  = 1'b1;
        pc_hold = 1'b1;
        flush   = 1'b1;
        if (resume) w_state_next = S_RUN;
      end
      default: w_state_next = S_INIT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= S_INIT;
      r_cnt          <= 4'd0;
      r_flush_q      <= 1'b1;
      r_cycle_count  <= 32'd0;
      r_instr_count  <= 32'd0;
      r_branch_count <= 16'd0;
    end else begin
      r_state       <= w_state_next;
      r_cnt         <= w_cnt_next;
      r_flush_q     <= flush;
      r_cycle_count <= r_cycle_count + 32'd1;
      if (w_accept) r_instr_count <= r_instr_count + 32'd1;
      if (w_taken)  r_branch_count <= r_branch_count + 16'd1;
    end
  end

  assign Reg_Write_c     = w_run & w_reg_write;
  assign Mem_Read_c      = w_run & w_mem_read;
  assign Mem_Write_c     = w_run & w_mem_write;
  assign Mem_to_Reg_c    = w_run & w_mem_to_reg;
  assign Reg_Dst_c       = w_run & w_reg_dst;
  assign ALU_src_c       = w_run ? w_alu_src : 2'b00;
  assign ALU_operation_c = w_run ? w_alu_op : 3'b000;
  assign cycle_count     = r_cycle_count;
  assign instr_count     = r_instr_count;
  assign branch_count    = r_branch_count;
  assign dbg_state       = r_state;

endmodule
